// File: rtl/bkram_sector_ctrl_if.sv
// SD sector request channel and in-line format write port of the backup-RAM controller.
interface bkram_sector_ctrl_if #(
  parameter int SECTORS_LOG2 = 4,
  parameter int BUF_AW       = 8
);
  logic [31:0]                    sd_lba;
  logic                           sd_rd;
  logic                           sd_wr;
  logic                           sd_ack;
  logic [SECTORS_LOG2+BUF_AW-1:0] fmt_addr;
  logic [15:0]                    fmt_data;
  logic                           fmt_we;

  modport master (
    output sd_lba, sd_rd, sd_wr, fmt_addr, fmt_data, fmt_we,
    input  sd_ack
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr, fmt_addr, fmt_data, fmt_we,
    output sd_ack
  );
endinterface

// File: rtl/bkram_sector_ctrl.sv
// Backup-RAM persistence controller: slot load/save over the SD sector channel,
// header format engine, dirty tracking, autosave and ack timeout.
module bkram_sector_ctrl #(
  parameter int          SECTORS_LOG2 = 4,
  parameter int          SLOTS_LOG2   = 2,
  parameter int          BUF_AW       = 8,
  parameter logic [23:0] ACK_TIMEOUT  = 24'd5000000
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [SLOTS_LOG2-1:0] slot,
  input  logic                  load_req,
  input  logic                  save_req,
  input  logic                  format_req,
  input  logic                  autosave_en,
  input  logic                  autosave_tick,
  input  logic                  bram_we,
  bkram_sector_ctrl_if.master   bus,
  output logic                  busy,
  output logic                  loading,
  output logic                  dirty,
  output logic                  done,
  output logic                  err
);
  localparam int FMT_AW = SECTORS_LOG2 + BUF_AW;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FORMAT = 3'd1,
    S_REQ    = 3'd2,
    S_XFER   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Save-image header written by the format engine.
  function automatic logic [15:0] fmt_word(input logic [1:0] idx);
    case (idx)
      2'd0:    fmt_word = 16'h5548;
      2'd1:    fmt_word = 16'h4D42;
      2'd2:    fmt_word = 16'h8800;
      2'd3:    fmt_word = 16'h8010;
      default: fmt_word = 16'h0000;
    endcase
  endfunction

  state_t                  state_r;
  logic                    load_q_r, save_q_r, fmt_q_r, ack_q_r;
  logic                    mode_load_r;
  logic [SLOTS_LOG2-1:0]   slot_r;
  logic [SECTORS_LOG2-1:0] idx_r;
  logic [23:0]             tmo_cnt_r;
  logic [1:0]              fmt_cnt_r;

  logic                    load_rise_s, save_rise_s, fmt_rise_s;
  logic                    ack_rise_s, ack_fall_s, auto_s;
  logic                    tmo_hit_s, idx_last_s, dirty_set_s;
  logic [SECTORS_LOG2-1:0] idx_nxt_s;

  // Trigger edges, arbitration qualifiers and sector/timeout decodes.
  always_comb begin
    load_rise_s = load_req & ~load_q_r;
    save_rise_s = save_req & ~save_q_r;
    fmt_rise_s  = format_req & ~fmt_q_r;
    ack_rise_s  = bus.sd_ack & ~ack_q_r;
    ack_fall_s  = ~bus.sd_ack & ack_q_r;
    auto_s      = autosave_tick & autosave_en & dirty & enable;
    tmo_hit_s   = (tmo_cnt_r == (ACK_TIMEOUT - 24'd1));
    idx_last_s  = &idx_r;
    idx_nxt_s   = idx_r + {{(SECTORS_LOG2-1){1'b0}}, 1'b1};
    dirty_set_s = bram_we & ~loading;
  end

  // Main sequencer with registered outputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= S_IDLE;
      load_q_r     <= 1'b1;
      save_q_r     <= 1'b1;
      fmt_q_r      <= 1'b1;
      ack_q_r      <= 1'b0;
      mode_load_r  <= 1'b0;
      slot_r       <= '0;
      idx_r        <= '0;
      tmo_cnt_r    <= 24'd0;
      fmt_cnt_r    <= 2'd0;
      bus.sd_lba   <= 32'd0;
      bus.sd_rd    <= 1'b0;
      bus.sd_wr    <= 1'b0;
      bus.fmt_addr <= '0;
      bus.fmt_data <= 16'h0000;
      bus.fmt_we   <= 1'b0;
      busy         <= 1'b0;
      loading      <= 1'b0;
      dirty        <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      load_q_r <= load_req;
      save_q_r <= save_req;
      fmt_q_r  <= format_req;
      ack_q_r  <= bus.sd_ack;
      done     <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (fmt_rise_s) begin
            state_r   <= S_FORMAT;
            busy      <= 1'b1;
            fmt_cnt_r <= 2'd0;
          end else if ((load_rise_s & enable) | (save_rise_s & enable) | auto_s) begin
            mode_load_r <= load_rise_s & enable;
            loading     <= load_rise_s & enable;
            slot_r      <= slot;
            idx_r       <= '0;
            bus.sd_lba  <= 32'({slot, {SECTORS_LOG2{1'b0}}});
            tmo_cnt_r   <= 24'd0;
            err         <= 1'b0;
            busy        <= 1'b1;
            state_r     <= S_REQ;
            if (!(load_rise_s & enable)) begin
              dirty <= 1'b0;
            end
          end
        end
        S_FORMAT: begin
          bus.fmt_we   <= 1'b1;
          bus.fmt_addr <= FMT_AW'(fmt_cnt_r);
          bus.fmt_data <= fmt_word(fmt_cnt_r);
          fmt_cnt_r    <= fmt_cnt_r + 2'd1;
          if (fmt_cnt_r == 2'd3) begin
            dirty   <= 1'b1;
            state_r <= S_DONE;
          end
        end
        S_REQ: begin
          if (ack_rise_s) begin
            bus.sd_rd <= 1'b0;
            bus.sd_wr <= 1'b0;
            state_r   <= S_XFER;
          end else if (tmo_hit_s) begin
            bus.sd_rd <= 1'b0;
            bus.sd_wr <= 1'b0;
            err       <= 1'b1;
            state_r   <= S_DONE;
          end else begin
            bus.sd_rd <= mode_load_r;
            bus.sd_wr <= ~mode_load_r;
            tmo_cnt_r <= tmo_cnt_r + 24'd1;
          end
        end
        S_XFER: begin
          if (ack_fall_s) begin
            if (idx_last_s) begin
              state_r <= S_DONE;
            end else begin
              idx_r      <= idx_nxt_s;
              bus.sd_lba <= 32'({slot_r, idx_nxt_s});
              tmo_cnt_r  <= 24'd0;
              state_r    <= S_REQ;
            end
          end
        end
        S_DONE: begin
          // Only a load that completed without timeout makes RAM match the image.
          if (loading & ~err) begin
            dirty <= 1'b0;
          end
          done       <= 1'b1;
          bus.fmt_we <= 1'b0;
          busy       <= 1'b0;
          loading    <= 1'b0;
          state_r    <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
      // Core writes win over any clear in the same cycle.
      if (dirty_set_s) begin
        dirty <= 1'b1;
      end
    end
  end
endmodule

// File: doc/bkram_sector_ctrl.md
Name: bkram_sector_ctrl

Overview:
- Backup-RAM persistence controller sitting between the core's backup RAM (dual-port, sector-addressed B side) and the hps_io SD sector interface.
- Successor to the fixed 16-sector, 4-slot save/load sequencer, parametrised in sector count and slot count.
- Adds an in-line format engine, dirty tracking, tick-driven autosave, ack timeout with sticky error, and defined arbitration of simultaneous requests.

Parameters:
SECTORS_LOG2, 4, log2 of sectors per save slot.
SLOTS_LOG2, 2, log2 of save slots.
BUF_AW, 8, log2 of 16-bit words per sector; sets the format address width.
ACK_TIMEOUT, 24'd5000000, clk_sys cycles allowed in REQ for sd_ack to rise.

Ports:
clk_sys  in  1  system clock.
reset_n  in  1  asynchronous, active-low reset.
enable  in  1  save image mounted and writable.
slot  in  SLOTS_LOG2  selected slot; sampled when a request is accepted.
load_req  in  1  level; its rising edge requests a load.
save_req  in  1  level; its rising edge requests a save.
format_req  in  1  level; its rising edge requests a format.
autosave_en  in  1  enables autosave.
autosave_tick  in  1  one-cycle pulse marking an autosave opportunity.
bram_we  in  1  core write strobe to backup RAM; feeds dirty tracking.
sd_lba  out  32  sector address.
sd_rd  out  1  sector read request.
sd_wr  out  1  sector write request.
sd_ack  in  1  HPS transfer acknowledge.
fmt_addr  out  SECTORS_LOG2+BUF_AW  format word address.
fmt_data  out  16  format word.
fmt_we  out  1  format write strobe.
busy  out  1  state is not IDLE.
loading  out  1  load in progress; holds the core in reset.
dirty  out  1  backup RAM has unsaved writes.
done  out  1  one-cycle pulse when an operation ends.
err  out  1  sticky timeout flag.

Behaviour:
- Reset: every output is 0, sd_lba is 0, state is IDLE.
- Edge detectors reset to 1, so a request held high through reset does not trigger.
- States: IDLE, FORMAT, REQ, XFER, DONE.
- IDLE arbitration when several triggers arrive in the same cycle: format > load > save > autosave.
  - Format is accepted regardless of enable.
  - Load and save require enable=1.
  - Autosave requires autosave_tick & autosave_en & dirty & enable.
  - Edges that arrive while busy are dropped, not queued.
- Accepting a load or save:
  - Latches slot and mode; sector index is set to 0.
  - err is cleared.
  - A save clears dirty at accept.
- sd_lba = {zeros, slot_latched, sector_idx}, width SLOTS_LOG2+SECTORS_LOG2, zero-extended to 32 bits.
- REQ:
  - sd_rd=mode_load and sd_wr=~mode_load, asserted the cycle after entry.
  - On sd_ack rising edge: sd_rd and sd_wr drop on the next cycle; go to XFER.
  - Timeout counter starts at 0 on entering REQ. When it reaches ACK_TIMEOUT-1 without an ack: sd_rd and sd_wr drop, err is set, go to DONE.
- XFER, on sd_ack falling edge:
  - If sector_idx is all-ones: go to DONE.
  - Otherwise: sector_idx+1 (no wrap past the slot), back to REQ.
- loading: high from load accept through the DONE cycle inclusive; low for save and format.
- DONE: done=1 for one cycle, then IDLE.
  - A successful load clears dirty.
  - A timed-out load leaves dirty unchanged.
- FORMAT:
  - Writes 4 header words on consecutive cycles: addr 0..3, data 16'h5548, 16'h4D42, 16'h8800, 16'h8010.
  - fmt_we is high for exactly those 4 cycles.
  - Then sets dirty and goes to DONE.
  - No SD traffic.
- dirty:
  - Set by bram_we whenever loading=0, including during a save, so writes that land mid-save are preserved.
  - Where bram_we coincides with the clear at save accept, set wins.
- enable falling mid-transfer does not abort the transfer; the sequence completes or times out.
- reset_n asserted mid-operation: immediate return to reset values; sd_rd, sd_wr and loading drop asynchronously.
- Latency: accept to first sd_rd or sd_wr is 2 cycles.

Test Plan:
- Load, slot=2, defaults: rising load_req, then a model acks each sector (rise 3 cycles after request, fall 256 cycles later) -> sd_lba 0x20..0x2F in order; 16 sd_rd pulses; loading high throughout; one done pulse; dirty=0.
- Save while dirty: bram_we pulse, save_req edge, slot=1 -> sd_lba 0x10..0x1F with sd_wr; dirty clears at accept. A bram_we at sector 5 -> dirty=1 at done.
- Simultaneous format_req and load_req edges -> format wins: fmt_we high 4 cycles at addr 0..3 with 5548/4D42/8800/8010, no sd_rd, dirty=1, done pulse. The load edge is dropped.
- Timeout with ACK_TIMEOUT=16: save with no ack -> sd_wr drops after 16 cycles in REQ; err=1; done pulses. The next accepted save clears err.
- Autosave: autosave_en=1, dirty=1, enable=1, tick pulse -> save of the current slot. Repeat with dirty=0 or enable=0 -> no activity.
- reset_n low during XFER of sector 7 -> all outputs 0 immediately. After release with load_req still high -> no new operation until a fresh rising edge.
